// File: rtl/fifo_sched_pkg.sv
// Shared types and width helpers for the FIFO round-robin scheduler and its arbiter.
package fifo_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } sched_state_e;

    localparam int unsigned DEF_CH_NUM     = 4;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_BURST_MAX  = 4;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned burst_max);
        return $clog2(burst_max + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after last_ptr, wrapping.
module rr_pick
    import fifo_sched_pkg::*;
#(
    parameter int unsigned CH_NUM = DEF_CH_NUM,
    localparam int unsigned IDX_W = idx_width(CH_NUM)
) (
    input  logic [CH_NUM-1:0] req,
    input  logic [IDX_W-1:0]  last_ptr,
    output logic [IDX_W-1:0]  pick,
    output logic              valid
);

    logic [2*CH_NUM-1:0] req_dbl;
    int unsigned         pos;

    assign req_dbl = {req, req};

    // Scan the doubled vector from farthest to nearest so the nearest hit is written last.
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        pos   = 0;
        for (int unsigned k = CH_NUM; k >= 1; k--) begin
            pos = int'(last_ptr) + k;
            if (req_dbl[pos]) begin
                valid = 1'b1;
                pick  = (pos > CH_NUM - 1) ? IDX_W'(pos - CH_NUM) : IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Round-robin scheduler draining up to BURST_MAX words per grant from FWFT channel FIFOs
// into one shared downstream FIFO write port.
module fifo_rr_scheduler
    import fifo_sched_pkg::*;
#(
    parameter int unsigned CH_NUM     = DEF_CH_NUM,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned BURST_MAX  = DEF_BURST_MAX,
    localparam int unsigned IDX_W     = idx_width(CH_NUM),
    localparam int unsigned CNT_W     = cnt_width(BURST_MAX)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CH_NUM-1:0]            ch_empty,
    input  logic [CH_NUM*DATA_WIDTH-1:0] ch_dout,
    output logic [CH_NUM-1:0]            ch_rd_en,
    output logic [DATA_WIDTH-1:0]        out_din,
    output logic                         out_wr_en,
    input  logic                         out_full,
    output logic [IDX_W-1:0]             grant_id,
    output logic                         busy
);

    sched_state_e    state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_ptr_q, last_ptr_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic [DATA_WIDTH-1:0] dout_arr [CH_NUM];
    logic [IDX_W-1:0]      pick;
    logic                  pick_valid;
    logic                  xfer;

    for (genvar i = 0; i < CH_NUM; i++) begin : g_split
        assign dout_arr[i] = ch_dout[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .CH_NUM(CH_NUM)
    ) u_rr_pick (
        .req     (~ch_empty),
        .last_ptr(last_ptr_q),
        .pick    (pick),
        .valid   (pick_valid)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_ptr_d  = last_ptr_q;
        burst_cnt_d = burst_cnt_q;
        ch_rd_en    = '0;
        out_wr_en   = 1'b0;
        out_din     = '0;
        xfer        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d     = pick;
                    burst_cnt_d = '0;
                    state_d     = BURST;
                end
            end
            BURST: begin
                xfer = ~ch_empty[grant_q] & ~out_full;
                if (xfer) begin
                    ch_rd_en[grant_q] = 1'b1;
                    out_wr_en         = 1'b1;
                    out_din           = dout_arr[grant_q];
                    burst_cnt_d       = burst_cnt_q + CNT_W'(1);
                    if (burst_cnt_q == CNT_W'(BURST_MAX - 1)) begin
                        state_d    = IDLE;
                        last_ptr_d = grant_q;
                    end
                end else if (ch_empty[grant_q]) begin
                    // A dry channel ends the burst even while downstream is full.
                    state_d    = IDLE;
                    last_ptr_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            last_ptr_q  <= IDX_W'(CH_NUM - 1);
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_ptr_q  <= last_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q == BURST);

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler with FWFT channel models and a word/burst scoreboard.
module tb_fifo_rr_scheduler;

    localparam int CH = 4;
    localparam int W  = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [CH-1:0]   ch_empty = '1;
    logic [CH*W-1:0] ch_dout = '0;
    logic [CH-1:0]   ch_rd_en;
    logic [W-1:0]    out_din;
    logic            out_wr_en;
    logic            out_full = 1'b0;
    logic [1:0]      grant_id;
    logic            busy;

    fifo_rr_scheduler #(
        .CH_NUM    (CH),
        .DATA_WIDTH(W),
        .BURST_MAX (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ch_empty (ch_empty),
        .ch_dout  (ch_dout),
        .ch_rd_en (ch_rd_en),
        .out_din  (out_din),
        .out_wr_en(out_wr_en),
        .out_full (out_full),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int gid;
        int len;
    } burst_t;

    logic [W-1:0] ch_q  [CH][$];
    logic [W-1:0] exp_q [CH][$];
    burst_t       exp_burst[$];

    int          n_checks = 0;
    int          n_err    = 0;
    logic [63:0] trace    = '0;
    logic        prev_busy = 1'b0;
    int          burst_writes = 0;
    int          last_g = 0;
    logic        s_busy, s_wr;
    logic [1:0]  s_grant;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic update_inputs();
        for (int i = 0; i < CH; i++) begin
            ch_empty[i] = (ch_q[i].size() == 0);
            ch_dout[i*W +: W] = (ch_q[i].size() == 0) ? 8'hEE : ch_q[i][0];
        end
    endtask

    task automatic load(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            ch_q[ch].push_back(8'(16 * ch + k + 1));
            exp_q[ch].push_back(8'(16 * ch + k + 1));
        end
        update_inputs();
    endtask

    task automatic push_burst(input int gid, input int len);
        burst_t b;
        b.gid = gid;
        b.len = len;
        exp_burst.push_back(b);
    endtask

    // One clock: sample at negedge, score, then apply pops after the edge.
    task automatic cyc();
        logic       w, b;
        logic [3:0] rd;
        logic [1:0] g;
        logic [7:0] d, e;
        burst_t     eb;
        @(negedge clk);
        w = out_wr_en; rd = ch_rd_en; g = grant_id; b = busy; d = out_din;
        s_wr = w; s_busy = b; s_grant = g;
        trace = {trace[62:0], w};
        if (w) begin
            chk("rd_en_onehot", 32'(rd), 32'(4'b0001 << g));
            chk("word_available", 32'(exp_q[g].size() != 0), 32'd1);
            if (exp_q[g].size() != 0) begin
                e = exp_q[g].pop_front();
                chk("out_din", 32'(d), 32'(e));
            end
            burst_writes++;
        end else begin
            chk("quiet_outputs", 32'({rd, d}), 32'd0);
        end
        if (b) last_g = int'(g);
        if (!b && prev_busy) begin
            chk("burst_queued", 32'(exp_burst.size() != 0), 32'd1);
            if (exp_burst.size() != 0) begin
                eb = exp_burst.pop_front();
                chk("burst_grant", 32'(last_g), 32'(eb.gid));
                chk("burst_len", 32'(burst_writes), 32'(eb.len));
            end
            burst_writes = 0;
        end
        prev_busy = b;
        @(posedge clk);
        #1;
        for (int i = 0; i < CH; i++)
            if (rd[i] && ch_q[i].size() != 0) void'(ch_q[i].pop_front());
        update_inputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        prev_busy = 1'b0;
        burst_writes = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic end_checks(input string tag);
        int left = 0;
        for (int i = 0; i < CH; i++) left += exp_q[i].size();
        chk({tag, "_words_left"}, 32'(left), 32'd0);
        chk({tag, "_bursts_left"}, 32'(exp_burst.size()), 32'd0);
    endtask

    initial begin
        // Reset state with all channels empty
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_outputs", 32'({ch_rd_en, out_wr_en, out_din}), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        do_reset();
        trace = '0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            chk("empty_busy", 32'(s_busy), 32'd0);
            chk("empty_grant", 32'(s_grant), 32'd0);
        end
        chk("empty_trace", 32'(trace[9:0]), 32'd0);

        // Only ch2 with 6 words: 4-word burst, re-arbitration, 2-word burst
        do_reset();
        load(2, 6);
        push_burst(2, 4);
        push_burst(2, 2);
        trace = '0;
        repeat (10) cyc();
        chk("ch2_trace", 32'(trace[9:0]), 32'(10'b0111101100));
        chk("ch2_grant_held", 32'(s_grant), 32'd2);
        end_checks("ch2");

        // All channels with 8 words: strict rotation, 4 words per grant
        do_reset();
        for (int i = 0; i < CH; i++) load(i, 8);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < CH; i++) push_burst(i, 4);
        repeat (45) cyc();
        end_checks("rotate");

        // ch1 stalled by out_full after 2 words
        do_reset();
        load(1, 4);
        push_burst(1, 4);
        trace = '0;
        repeat (3) cyc();
        out_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cyc();
            chk("stall_no_write", 32'(s_wr), 32'd0);
            chk("stall_busy", 32'(s_busy), 32'd1);
            chk("stall_cnt", 32'(dut.burst_cnt_q), 32'd2);
        end
        out_full = 1'b0;
        repeat (3) cyc();
        chk("stall_trace", 32'(trace[10:0]), 32'(11'b01100000110));
        end_checks("stall");

        // last_ptr=2, then ch3 (1 word) served before wrapping to ch0 (3 words)
        do_reset();
        load(2, 1);
        push_burst(2, 1);
        repeat (5) cyc();
        load(3, 1);
        load(0, 3);
        push_burst(3, 1);
        push_burst(0, 3);
        trace = '0;
        repeat (12) cyc();
        chk("wrap_trace", 32'(trace[11:0]), 32'(12'b010011100000));
        end_checks("wrap");

        // Reset mid-burst after 2 words of ch0
        do_reset();
        load(0, 4);
        repeat (3) cyc();
        rst = 1'b1;
        #1;
        chk("midrst_outputs", 32'({ch_rd_en, out_wr_en, out_din}), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_grant", 32'(grant_id), 32'd0);
        chk("midrst_words", 32'(burst_writes), 32'd2);
        burst_writes = 0;
        prev_busy = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        push_burst(0, 2);
        repeat (6) cyc();
        end_checks("midrst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
